// File: rtl/uart_tx_msg_serializer.sv
// Message serializer: fetches MSG_LEN ROM characters and sends each as an 8N1 UART frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_msg_serializer #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MSG_LEN  = 84
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             increment,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CharW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WIDTH - 1);
  localparam logic [CharW-1:0] CharLast = CharW'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e             state_q, state_d;
  logic [BaudW-1:0]   baud_q, baud_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [CharW-1:0]   char_q, char_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               inc_q, inc_d;
  logic               baud_end;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  assign baud_end = (baud_q == BaudLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      char_q   <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      inc_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      char_q   <= char_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      inc_q    <= inc_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad:   state_d = StStart;
      StStart:  if (baud_end) state_d = StData;
      StData: begin
        if (baud_end && bit_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: if (baud_end) state_d = StStop;
`endif
      StStop:   if (baud_end) state_d = (char_q == CharLast) ? StIdle : StLoad;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath counters: baud counter restarts on every state change so bit periods never jitter.
  always_comb begin
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    char_d  = char_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_d != state_q || baud_end || state_q == StIdle) baud_d = '0;
    if (state_d != StData) begin
      bit_d = '0;
    end else if (state_q == StData && baud_end) begin
      bit_d = bit_q + 1'b1;
    end
    if (state_q == StIdle && start) begin
      char_d = '0;
    end else if (state_q == StStop && baud_end && char_q != CharLast) begin
      char_d = char_q + 1'b1;
    end
    if (state_q == StLoad) begin
      shift_d = data_in;
`ifdef UART_TX_PARITY_EN
      parity_d = ^data_in;
`endif
    end else if (state_q == StData && baud_end) begin
      shift_d = shift_q >> 1;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != StIdle);
    inc_d  = (state_d == StLoad);
    done_d = (state_q == StStop) && (state_d == StIdle);
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign increment = inc_q;

endmodule

// File: tb/tb_uart_tx_msg_serializer.sv
// Bench for uart_tx_msg_serializer: single-frame timing table, reset, full and back-to-back messages.
module tb_uart_tx_msg_serializer;

  localparam int unsigned CF  = 1000;
  localparam int unsigned BR  = 100;
  localparam int unsigned CPB = CF / BR;
  localparam int unsigned W   = 8;
  localparam int unsigned ML  = 84;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned FRAME = 1 + (2 + W + PB) * CPB;

  typedef struct {
    int unsigned off;
    logic [3:0]  exp;  // {tx, increment, busy, done}
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic [7:0] rom_data;
  logic       increment, tx, busy, done;
  logic       inc1, tx1, busy1, done1;
  logic [6:0] addr_q;

  int n_vec = 0;
  int n_err = 0;
  int inc_cnt, done_cnt, busy_cnt, inc1_cnt;
  logic [7:0] exp_q[$];
  vec_t vecs[$];

  bit         mon_en = 1'b0;
  bit         mon_act = 1'b0;
  int         mon_pos;
  logic       mon_start_ok;
  logic       mon_par;
  logic [7:0] mon_byte;

  always #5 clk = ~clk;

  uart_tx_msg_serializer #(
    .CLK_FREQ(CF), .BAUD(BR), .WIDTH(W), .MSG_LEN(ML)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .data_in(rom_data),
    .increment(increment), .tx(tx), .busy(busy), .done(done)
  );

  uart_tx_msg_serializer #(
    .CLK_FREQ(CF), .BAUD(BR), .WIDTH(W), .MSG_LEN(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(8'h41),
    .increment(inc1), .tx(tx1), .busy(busy1), .done(done1)
  );

  function automatic logic [7:0] rom_word(int i);
    return 8'(8'h41 + 2 * i);
  endfunction

  // ROM + address counter model: registered read, data follows increment by two cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      rom_data <= '0;
    end else begin
      if (increment) addr_q <= (addr_q == 7'(ML - 1)) ? 7'd0 : addr_q + 7'd1;
      rom_data <= rom_word(int'(addr_q));
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic end_frame();
    logic [7:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_frame: got byte %0h expected no frame", mon_byte);
    end else begin
      n_vec--;
      e = exp_q.pop_front();
      chk("rx_byte", {24'd0, mon_byte}, {24'd0, e});
      chk("start_bit", {31'd0, mon_start_ok}, 32'd1);
      chk("stop_bit", {31'd0, tx}, 32'd1);
`ifdef UART_TX_PARITY_EN
      chk("parity_bit", {31'd0, mon_par}, {31'd0, ^e});
`endif
    end
  endtask

  // One clock: sample at the falling edge, count flags, advance the tx decoder.
  task automatic tick();
    int k;
    @(negedge clk);
    inc_cnt  += int'(increment);
    done_cnt += int'(done);
    busy_cnt += int'(busy);
    inc1_cnt += int'(inc1);
    if (mon_en) begin
      if (!mon_act) begin
        if (tx == 1'b0) begin
          mon_act = 1'b1;
          mon_pos = 0;
        end
      end else begin
        mon_pos++;
      end
      if (mon_act && mon_pos >= 4 && (mon_pos - 4) % CPB == 0) begin
        k = (mon_pos - 4) / CPB;
        if (k == 0) mon_start_ok = (tx == 1'b0);
        else if (k <= W) mon_byte[k-1] = tx;
        else if (k == W + 1 + PB) begin
          end_frame();
          mon_act = 1'b0;
        end else mon_par = tx;
      end
    end
  endtask

  task automatic wait_dones(int target, int budget, string name);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt >= target) break;
    end
    chk(name, done_cnt, target);
  endtask

  task automatic clear_counts();
    inc_cnt = 0; done_cnt = 0; busy_cnt = 0; inc1_cnt = 0;
  endtask

  initial begin
    logic [7:0] ch;
    int unsigned s;
    int vi;
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    clear_counts();

    ch = 8'h41;
    vecs.push_back('{0, 4'b1110, "load"});
    vecs.push_back('{1, 4'b0010, "start_first"});
    vecs.push_back('{CPB, 4'b0010, "start_last"});
    for (int b = 0; b < 8; b++) begin
      vecs.push_back('{1 + CPB * (b + 1), {ch[b], 3'b010}, "data_first"});
      vecs.push_back('{CPB * (b + 2), {ch[b], 3'b010}, "data_last"});
    end
    s = 1 + (1 + W) * CPB;
`ifdef UART_TX_PARITY_EN
    vecs.push_back('{s, {^ch, 3'b010}, "parity_first"});
    vecs.push_back('{s + CPB - 1, {^ch, 3'b010}, "parity_last"});
    s = s + CPB;
`endif
    vecs.push_back('{s, 4'b1010, "stop_first"});
    vecs.push_back('{s + CPB - 1, 4'b1010, "stop_last"});
    vecs.push_back('{FRAME, 4'b1001, "done"});
    vecs.push_back('{FRAME + 1, 4'b1000, "after_done"});

    #2 rst = 1'b0;
    repeat (2) tick();
    chk("reset_state", {28'd0, tx, increment, busy, done}, 32'b1000);
    chk("reset_state1", {28'd0, tx1, inc1, busy1, done1}, 32'b1000);
    rst = 1'b1;
    repeat (2) tick();

    // Single-frame timing table on the one-character instance.
    clear_counts();
    start1 = 1'b1;
    vi = 0;
    for (int k = 0; k <= int'(FRAME) + 1; k++) begin
      tick();
      if (k == 0) start1 = 1'b0;
      if (vi < vecs.size() && vecs[vi].off == k) begin
        chk(vecs[vi].name, {28'd0, tx1, inc1, busy1, done1}, {28'd0, vecs[vi].exp});
        vi++;
      end
    end
    chk("table_exhausted", vi, vecs.size());
    chk("inc1_pulses", inc1_cnt, 1);

    // Asynchronous reset in the middle of a data-0 bit.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (24) tick();
    chk("pre_reset_tx", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    #1;
    chk("async_reset", {28'd0, tx, increment, busy, done}, 32'b1000);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // Full message with a stray start while busy.
    clear_counts();
    mon_en = 1'b1;
    for (int i = 0; i < int'(ML); i++) exp_q.push_back(rom_word(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3000) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_dones(1, int'(FRAME * ML) + 100, "msg_done");
    chk("msg_increments", inc_cnt, ML);
    chk("msg_busy_cycles", busy_cnt, ML * FRAME);
    chk("msg_all_rx", exp_q.size(), 0);
    repeat (300) tick();
    chk("no_queued_start", busy_cnt, ML * FRAME);
    chk("single_done", done_cnt, 1);

    // Back-to-back messages with start held high.
    clear_counts();
    for (int i = 0; i < 2 * int'(ML); i++) exp_q.push_back(rom_word(i % int'(ML)));
    start = 1'b1;
    wait_dones(1, int'(FRAME * ML) + 100, "b2b_done1");
    chk("b2b_idle_at_done", {31'd0, busy}, 32'd0);
    tick();
    chk("b2b_restart", {30'd0, busy, increment}, 32'b11);
    repeat (5) tick();
    start = 1'b0;
    wait_dones(2, int'(FRAME * ML) + 100, "b2b_done2");
    chk("b2b_increments", inc_cnt, 2 * ML);
    chk("b2b_busy_cycles", busy_cnt, 2 * ML * FRAME);
    chk("b2b_all_rx", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
